pkt_field_reader: RTL

- Initiator that drives the width-based load port of `mem` (ce/we/addr/width/data).
- Fetches a multi-byte packet header field, 1..8 bytes at any byte address, from packet SRAM.
- Splits the field into aligned word/half/byte loads and assembles the bytes big-endian.
- Returns the field on a valid/ready response channel; sits between the parser stage and `mem`.

---
 rtl/pkt_field_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_field_reader.sv
// pkt_field_reader: fetches a 1..MAX_BYTES byte big-endian header field
// from packet SRAM at any byte address through the width-based load port.
// Ports: clk, rst (async, active-low); request req_valid/req_ready/req_addr/
// req_len; response rsp_valid/rsp_ready/rsp_data (+ rsp_err);
// memory mem_ce/mem_we/mem_addr_o/mem_width_o/mem_data_o/mem_data_i.
// Optional macro PKT_FIELD_CHK_EN: reject len 0 or len > MAX_BYTES via rsp_err.

`ifndef ADDR_BUS
`define ADDR_BUS 31:0
`endif
`ifndef DATA_BUS
`define DATA_BUS 31:0
`endif

module pkt_field_reader #(
    parameter int MAX_BYTES = 8,
    parameter int LEN_W     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [`ADDR_BUS]       req_addr,
    input  logic [LEN_W-1:0]       req_len,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*MAX_BYTES-1:0] rsp_data,
`ifdef PKT_FIELD_CHK_EN
    output logic                   rsp_err,
`endif
    output logic                   mem_ce,
    output logic                   mem_we,
    output logic [`ADDR_BUS]       mem_addr_o,
    output logic [3:0]             mem_width_o,
    output logic [`DATA_BUS]       mem_data_o,
    input  logic [`DATA_BUS]       mem_data_i
);

    typedef logic [`ADDR_BUS] addr_t;

    localparam int AW = $bits(addr_t);
    localparam int DW = 8 * MAX_BYTES;
    localparam logic [LEN_W:0] LP_MAX = (LEN_W + 1)'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    addr_t            r_cur_addr;
    logic [LEN_W-1:0] r_rem;
    logic [DW-1:0]    r_acc;
`ifdef PKT_FIELD_CHK_EN
    logic             r_err;
`endif

    logic             w_hs;
    logic             w_len_zero;
    logic             w_len_big;
    logic             w_skip;
    logic [LEN_W-1:0] w_len_eff;
    logic             w_c4;
    logic             w_c2;
    logic [3:0]       w_width;
    logic [LEN_W-1:0] w_rem_nxt;
    addr_t            w_addr_nxt;
    logic [DW-1:0]    w_acc_nxt;

    assign w_hs       = req_valid && (r_state == S_IDLE);
    assign w_len_zero = (req_len == '0);
    assign w_len_big  = ({1'b0, req_len} > LP_MAX);
    assign w_len_eff  = w_len_big ? LP_MAX[LEN_W-1:0] : req_len;

`ifdef PKT_FIELD_CHK_EN
    assign w_skip = w_len_zero || w_len_big;
`else
    assign w_skip = w_len_zero;
`endif

    // Widest aligned load that fits the bytes still owed; the two
    // conditions are made exclusive so the decoder stays one-hot.
    assign w_c4 = (r_cur_addr[1:0] == 2'b00) && (r_rem >= LEN_W'(4));
    assign w_c2 = !w_c4 && !r_cur_addr[0] && (r_rem >= LEN_W'(2));

    always_comb begin
        w_width = 4'd1;
        unique case (1'b1)
            w_c4:    w_width = 4'd4;
            w_c2:    w_width = 4'd2;
            default: w_width = 4'd1;
        endcase
    end

    assign w_rem_nxt  = r_rem - LEN_W'(w_width);
    assign w_addr_nxt = r_cur_addr + AW'(w_width);

    // mem puts the lowest-address byte in the MSB of the returned width,
    // so shifting left and appending keeps the field big-endian.
    always_comb begin
        w_acc_nxt = r_acc;
        unique case (1'b1)
            (w_width == 4'd4): w_acc_nxt = (r_acc << 32) | DW'(mem_data_i[31:0]);
            (w_width == 4'd2): w_acc_nxt = (r_acc << 16) | DW'(mem_data_i[15:0]);
            default:           w_acc_nxt = (r_acc << 8)  | DW'(mem_data_i[7:0]);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        mem_ce      = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = w_skip ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_ce      = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                mem_ce      = 1'b1;
                w_state_nxt = (w_rem_nxt != '0) ? S_ISSUE : S_DONE;
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Address/width only leave zero while a load is in flight; cur_addr
    // and remaining do not move until the WAIT edge, so both hold.
    assign mem_addr_o  = mem_ce ? r_cur_addr : '0;
    assign mem_width_o = mem_ce ? w_width : 4'd0;
    assign mem_we      = 1'b0;
    assign mem_data_o  = '0;
    assign rsp_data    = rsp_valid ? r_acc : '0;
`ifdef PKT_FIELD_CHK_EN
    assign rsp_err     = rsp_valid && r_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_addr <= '0;
            r_rem      <= '0;
            r_acc      <= '0;
`ifdef PKT_FIELD_CHK_EN
            r_err      <= 1'b0;
`endif
        end else if (w_hs) begin
            r_cur_addr <= req_addr;
            r_rem      <= w_len_eff;
            r_acc      <= '0;
`ifdef PKT_FIELD_CHK_EN
            r_err      <= w_skip;
`endif
        end else if (r_state == S_WAIT) begin
            r_cur_addr <= w_addr_nxt;
            r_rem      <= w_rem_nxt;
            r_acc      <= w_acc_nxt;
        end
    end

endmodule
